demux_decoder: RTL and testbench

DEMUX_DECODER -- requirements
Module: demux_decoder

---
 rtl/demux_decoder.sv | 142 ++++++++++++++
 tb/tb_demux_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_decoder.sv
`default_nettype none
// ============================================================================
// Module   : demux_decoder
// Brief    : Pin-level channel latch and 1-of-32 decoder with CDC synchronizers
// Revision : 1.0 - initial release
// ============================================================================
module demux_decoder #(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena_n,
    input  logic        wr_n,
    input  logic        cs_n,
    input  logic [4:0]  set_ch_n,
    output logic [4:0]  ch_idx,
    output logic [31:0] ch_sel,
    output logic        latch_pulse,
    output logic        err_setup,
    output logic        stale,
    output logic [15:0] latch_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEL   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("demux_decoder: SYNC_STAGES must be in 2..4");
    end

    logic [7:0]                   w_pins;
    logic [SYNC_STAGES-1:0][7:0]  r_sync;
    logic [7:0]                   w_sync_out;
    logic                         w_ena_s;
    logic                         w_wr_s;
    logic                         w_cs_s;
    logic [4:0]                   w_addr_s;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_accept;
    logic [4:0]  w_idx_next;
    logic [4:0]  r_ch_idx;
    logic [31:0] r_ch_sel;
    logic        r_en;
    logic        r_latch_pulse;
    logic        r_err_setup;
    logic [4:0]  r_addr_entry;
    logic [15:0] r_latch_cnt;
    logic [23:0] r_stale_cnt;

    assign w_pins = {ena_n, wr_n, cs_n, set_ch_n};

    // Flops reset to 1 so the synchronized view matches idle-high pins.
    genvar s;
    for (s = 0; s < SYNC_STAGES; s++) begin : g_sync
        if (s == 0) begin : g_first
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_sync[s] <= '1;
                else      r_sync[s] <= w_pins;
            end
        end else begin : g_rest
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_sync[s] <= '1;
                else      r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_ena_s    = w_sync_out[7];
    assign w_wr_s     = w_sync_out[6];
    assign w_cs_s     = w_sync_out[5];
    assign w_addr_s   = ~w_sync_out[4:0];

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_cs_s) w_state_next = w_wr_s ? S_SEL : S_WRITE;
            end
            S_SEL: begin
                if (w_cs_s)       w_state_next = S_IDLE;
                else if (!w_wr_s) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                // A write-strobe release is accepted even if cs_n rises with it.
                if (w_wr_s) begin
                    w_accept     = 1'b1;
                    w_state_next = w_cs_s ? S_IDLE : S_SEL;
                end else if (w_cs_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_idx_next = w_accept ? w_addr_s : r_ch_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_ch_idx      <= '0;
            r_ch_sel      <= '0;
            r_en          <= 1'b0;
            r_latch_pulse <= 1'b0;
            r_err_setup   <= 1'b0;
            r_addr_entry  <= '0;
            r_latch_cnt   <= '0;
            r_stale_cnt   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_ch_idx      <= w_idx_next;
            r_ch_sel      <= r_en ? (32'd1 << w_idx_next) : 32'h0;
            r_en          <= ~w_ena_s;
            r_latch_pulse <= w_accept;
            if (w_state_next == S_WRITE && r_state != S_WRITE)
                r_addr_entry <= w_addr_s;
            if (r_state == S_WRITE && w_addr_s != r_addr_entry)
                r_err_setup <= 1'b1;
            if (w_accept && r_latch_cnt != 16'hFFFF)
                r_latch_cnt <= r_latch_cnt + 16'd1;
            if (w_accept)
                r_stale_cnt <= '0;
            else if (r_stale_cnt != TIMEOUT_CYCLES)
                r_stale_cnt <= r_stale_cnt + 24'd1;
        end
    end

    assign ch_idx      = r_ch_idx;
    assign ch_sel      = r_ch_sel;
    assign latch_pulse = r_latch_pulse;
    assign err_setup   = r_err_setup;
    assign stale       = (r_stale_cnt == TIMEOUT_CYCLES);
    assign latch_cnt   = r_latch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_decoder
// Brief    : Directed self-checking bench for demux_decoder
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_decoder;

    logic        clk;
    logic        rst;
    logic        ena_n;
    logic        wr_n;
    logic        cs_n;
    logic [4:0]  set_ch_n;
    logic [4:0]  ch_idx;
    logic [31:0] ch_sel;
    logic        latch_pulse;
    logic        err_setup;
    logic        stale;
    logic [15:0] latch_cnt;

    int vectors;
    int miscompares;
    int exp_cnt;
    logic seen_pulse;

    demux_decoder #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (24'd100)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ena_n       (ena_n),
        .wr_n        (wr_n),
        .cs_n        (cs_n),
        .set_ch_n    (set_ch_n),
        .ch_idx      (ch_idx),
        .ch_sel      (ch_sel),
        .latch_pulse (latch_pulse),
        .err_setup   (err_setup),
        .stale       (stale),
        .latch_cnt   (latch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write cycle: strobe low 4 clocks, then release; returns when the latch is visible.
    task automatic do_write(input logic [4:0] addr);
        set_ch_n = ~addr;
        cs_n     = 1'b0;
        wr_n     = 1'b0;
        step(4);
        wr_n = 1'b1;
        step(3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 0;
        rst      = 1'b0;
        ena_n    = 1'b1;
        wr_n     = 1'b1;
        cs_n     = 1'b1;
        set_ch_n = 5'h1F;
        step(2);

        check("rst_ch_idx", ch_idx, 0);
        check("rst_ch_sel", ch_sel, 0);
        check("rst_pulse", latch_pulse, 0);
        check("rst_err", err_setup, 0);
        check("rst_stale", stale, 0);
        check("rst_cnt", latch_cnt, 0);

        rst = 1'b1;
        step(99);
        check("stale_at_99", stale, 0);
        step(1);
        check("stale_at_100", stale, 1);
        step(5);
        check("stale_held", stale, 1);

        // Latch 7 with the output disabled.
        do_write(5'd7);
        exp_cnt++;
        check("dis_pulse", latch_pulse, 1);
        check("dis_stale_clr", stale, 0);
        check("dis_idx", ch_idx, 7);
        check("dis_sel", ch_sel, 0);
        check("dis_cnt", latch_cnt, exp_cnt);
        step(1);
        check("dis_pulse_end", latch_pulse, 0);

        ena_n = 1'b0;
        step(6);
        check("ena_sel", ch_sel, 32'h80);
        check("ena_cnt", latch_cnt, exp_cnt);

        // Same address again is still a counted latch.
        do_write(5'd7);
        exp_cnt++;
        check("rep_pulse", latch_pulse, 1);
        check("rep_idx", ch_idx, 7);
        check("rep_sel", ch_sel, 32'h80);
        check("rep_cnt", latch_cnt, exp_cnt);
        step(1);

        // cs_n rises while the strobe is still low: aborted write.
        set_ch_n   = ~5'd9;
        wr_n       = 1'b0;
        step(4);
        cs_n       = 1'b1;
        seen_pulse = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) wr_n = 1'b1;
            step(1);
            seen_pulse = seen_pulse | latch_pulse;
        end
        check("abort_no_pulse", seen_pulse, 0);
        check("abort_idx", ch_idx, 7);
        check("abort_cnt", latch_cnt, exp_cnt);
        check("abort_err", err_setup, 0);

        // Strobe and select released together: latch accepted.
        set_ch_n = ~5'd12;
        cs_n     = 1'b0;
        wr_n     = 1'b0;
        step(4);
        cs_n     = 1'b1;
        wr_n     = 1'b1;
        step(3);
        exp_cnt++;
        check("simul_pulse", latch_pulse, 1);
        check("simul_idx", ch_idx, 12);
        check("simul_sel", ch_sel, 32'h1000);
        check("simul_cnt", latch_cnt, exp_cnt);
        step(2);

        // Address changes during the write phase.
        set_ch_n = ~5'd3;
        cs_n     = 1'b0;
        wr_n     = 1'b0;
        step(4);
        set_ch_n = ~5'd4;
        step(3);
        wr_n = 1'b1;
        step(3);
        exp_cnt++;
        check("setup_err", err_setup, 1);
        check("setup_idx", ch_idx, 4);
        check("setup_cnt", latch_cnt, exp_cnt);
        step(2);

        for (int a = 0; a < 32; a++) begin
            do_write(a[4:0]);
            exp_cnt++;
            check("sweep_idx", ch_idx, a);
            check("sweep_sel", ch_sel, 32'd1 << a);
        end
        check("sweep_cnt", latch_cnt, exp_cnt);
        check("sweep_err_sticky", err_setup, 1);
        check("sweep_stale", stale, 0);
        step(1);

        // Reset in the middle of a write phase.
        set_ch_n = ~5'd21;
        wr_n     = 1'b0;
        step(4);
        rst = 1'b0;
        #1;
        check("arst_idx", ch_idx, 0);
        check("arst_sel", ch_sel, 0);
        check("arst_pulse", latch_pulse, 0);
        check("arst_err", err_setup, 0);
        check("arst_stale", stale, 0);
        check("arst_cnt", latch_cnt, 0);
        cs_n = 1'b1;
        step(2);
        rst = 1'b1;
        step(4);
        wr_n       = 1'b1;
        seen_pulse = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen_pulse = seen_pulse | latch_pulse;
        end
        check("post_rst_no_pulse", seen_pulse, 0);
        check("post_rst_idx", ch_idx, 0);
        check("post_rst_cnt", latch_cnt, 0);

        do_write(5'd5);
        check("post_rst_new_pulse", latch_pulse, 1);
        check("post_rst_new_idx", ch_idx, 5);
        check("post_rst_new_sel", ch_sel, 32'h20);
        check("post_rst_new_cnt", latch_cnt, 1);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
